// File: rtl/ctrl_pkg.sv
// Shared encodings for the multicycle controller: opcodes, ALU operation codes,
// FSM state enum and opcode class enum.
package ctrl_pkg;

    localparam logic [3:0] OPC_LB   = 4'b0000;
    localparam logic [3:0] OPC_LHB  = 4'b0001;
    localparam logic [3:0] OPC_JMP  = 4'b0010;
    localparam logic [3:0] OPC_STR  = 4'b0011;
    localparam logic [3:0] OPC_LIM  = 4'b0100;
    localparam logic [3:0] OPC_MVB  = 4'b0101;
    localparam logic [3:0] OPC_MVF  = 4'b0110;
    localparam logic [3:0] OPC_ADD  = 4'b0111;
    localparam logic [3:0] OPC_SUB  = 4'b1000;
    localparam logic [3:0] OPC_SFT  = 4'b1001;
    localparam logic [3:0] OPC_BNE  = 4'b1010;
    localparam logic [3:0] OPC_BEQ  = 4'b1011;
    localparam logic [3:0] OPC_BLT  = 4'b1100;
    localparam logic [3:0] OPC_INC  = 4'b1101;
    localparam logic [3:0] OPC_HALT = 4'b1110;
    localparam logic [3:0] OPC_TBA  = 4'b1111;

    localparam logic [3:0] ALU_ADD     = 4'b0000;
    localparam logic [3:0] ALU_SUB     = 4'b0001;
    localparam logic [3:0] ALU_SFT     = 4'b0010;
    localparam logic [3:0] ALU_SFT_IMM = 4'b0011;
    localparam logic [3:0] ALU_INC     = 4'b0100;
    localparam logic [3:0] ALU_DEC     = 4'b0101;
    localparam logic [3:0] ALU_BNE     = 4'b0110;
    localparam logic [3:0] ALU_BEQ     = 4'b0111;
    localparam logic [3:0] ALU_BLT     = 4'b1000;
    localparam logic [3:0] ALU_NONE    = 4'b0000;

    typedef enum logic [2:0] {
        ST_IDLE, ST_FETCH, ST_DECODE, ST_EXEC, ST_MEM, ST_WB, ST_HALT, ST_ERR
    } state_e;

    typedef enum logic [2:0] {
        CLS_NOP, CLS_ALU, CLS_BRANCH, CLS_JUMP, CLS_LOAD, CLS_STORE, CLS_MOVE, CLS_HALT
    } op_class_e;

endpackage

// File: rtl/ctrl_decode.sv
// Combinational opcode decoder: maps opcode/imm_flag to an opcode class and the
// ALU operation code used in EXEC/WB.
module ctrl_decode
    import ctrl_pkg::*;
#(
    parameter int OP_W  = 4,
    parameter int ALU_W = 4
) (
    input  logic [OP_W-1:0]  opcode,
    input  logic             imm_flag,
    output op_class_e        op_class,
    output logic [ALU_W-1:0] alu_code
);

    logic [3:0] op4;
    logic [3:0] alu4;
    logic       hi_zero;

    // Opcodes wider than four bits only decode when the extra bits are zero.
    assign hi_zero = ((opcode >> 4) == '0);
    assign op4     = 4'(opcode);

    always_comb begin
        op_class = CLS_NOP;
        alu4     = ALU_NONE;
        if (hi_zero) begin
            case (op4)
                OPC_ADD: begin op_class = CLS_ALU; alu4 = ALU_ADD; end
                OPC_SUB: begin op_class = CLS_ALU; alu4 = ALU_SUB; end
                OPC_SFT: begin op_class = CLS_ALU; alu4 = imm_flag ? ALU_SFT_IMM : ALU_SFT; end
                OPC_INC: begin op_class = CLS_ALU; alu4 = imm_flag ? ALU_INC : ALU_DEC; end
                OPC_BNE: begin op_class = CLS_BRANCH; alu4 = ALU_BNE; end
                OPC_BEQ: begin op_class = CLS_BRANCH; alu4 = ALU_BEQ; end
                OPC_BLT: begin op_class = CLS_BRANCH; alu4 = ALU_BLT; end
                OPC_JMP:  op_class = CLS_JUMP;
                OPC_LB, OPC_LHB: op_class = CLS_LOAD;
                OPC_STR:  op_class = CLS_STORE;
                OPC_LIM, OPC_MVB, OPC_MVF: op_class = CLS_MOVE;
                OPC_HALT: op_class = CLS_HALT;
                default:  op_class = CLS_NOP;
            endcase
        end
    end

    assign alu_code = ALU_W'(alu4);

endmodule

// File: rtl/multicycle_control.sv
// Multicycle CPU control FSM: fetch/decode/execute/memory/writeback sequencing,
// memory-wait timeout, retired-instruction counter.
module multicycle_control
    import ctrl_pkg::*;
#(
    parameter int OP_W  = 4,
    parameter int ALU_W = 4,
    parameter int CNT_W = 16,
    parameter int TMO   = 15
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [OP_W-1:0]  opcode,
    input  logic             imm_flag,
    input  logic             mem_ready,
    output logic             mem_req,
    output logic             mem_we,
    output logic             ir_load,
    output logic             pc_inc,
    output logic [ALU_W-1:0] alu_inst,
    output logic             write_reg,
    output logic             branch_en,
    output logic             jump_en,
    output logic             halted,
    output logic             error,
    output logic [CNT_W-1:0] retire_cnt
);

    // Wait counter only needs to reach TMO-1; the last permitted cycle is judged combinationally.
    localparam int WAIT_W = (TMO < 2) ? 1 : $clog2(TMO);

    state_e           state;
    state_e           state_next;
    op_class_e        dec_class;
    op_class_e        cls_q;
    logic [ALU_W-1:0] dec_alu;
    logic [ALU_W-1:0] alu_q;
    logic [WAIT_W-1:0] wait_cnt;
    logic             wait_expired;
    logic             retire;

    ctrl_decode #(.OP_W(OP_W), .ALU_W(ALU_W)) u_decode (
        .opcode   (opcode),
        .imm_flag (imm_flag),
        .op_class (dec_class),
        .alu_code (dec_alu)
    );

    assign wait_expired = !mem_ready && (wait_cnt == WAIT_W'(TMO - 1));

    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE:   if (start) state_next = ST_FETCH;
            ST_FETCH: begin
                if (mem_ready)         state_next = ST_DECODE;
                else if (wait_expired) state_next = ST_ERR;
            end
            ST_DECODE: begin
                case (dec_class)
                    CLS_ALU, CLS_BRANCH, CLS_JUMP: state_next = ST_EXEC;
                    CLS_LOAD, CLS_STORE:           state_next = ST_MEM;
                    CLS_MOVE:                      state_next = ST_WB;
                    CLS_HALT:                      state_next = ST_HALT;
                    default:                       state_next = ST_FETCH;
                endcase
            end
            ST_EXEC:   state_next = (cls_q == CLS_ALU) ? ST_WB : ST_FETCH;
            ST_MEM: begin
                if (mem_ready)         state_next = (cls_q == CLS_STORE) ? ST_FETCH : ST_WB;
                else if (wait_expired) state_next = ST_ERR;
            end
            ST_WB:     state_next = ST_FETCH;
            ST_HALT:   state_next = ST_HALT;
            ST_ERR:    state_next = ST_ERR;
            default:   state_next = ST_IDLE;
        endcase
    end

    // An instruction retires when it returns to FETCH or when HALT is entered.
    assign retire = ((state_next == ST_FETCH) &&
                     (state == ST_DECODE || state == ST_EXEC || state == ST_MEM || state == ST_WB)) ||
                    ((state_next == ST_HALT) && (state != ST_HALT));

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= ST_IDLE;
            cls_q      <= CLS_NOP;
            alu_q      <= '0;
            wait_cnt   <= '0;
            retire_cnt <= '0;
        end else begin
            state <= state_next;
            if (state == ST_DECODE) begin
                cls_q <= dec_class;
                alu_q <= dec_alu;
            end
            if (state_next != state)
                wait_cnt <= '0;
            else if ((state == ST_FETCH || state == ST_MEM) && !mem_ready)
                wait_cnt <= wait_cnt + 1'b1;
            if (retire)
                retire_cnt <= retire_cnt + 1'b1;
        end
    end

    // ir_load/pc_inc follow mem_ready in the completing FETCH cycle; everything else is Moore.
    assign mem_req   = (state == ST_FETCH) || (state == ST_MEM);
    assign mem_we    = (state == ST_MEM) && (cls_q == CLS_STORE);
    assign ir_load   = (state == ST_FETCH) && mem_ready;
    assign pc_inc    = (state == ST_FETCH) && mem_ready;
    assign alu_inst  = (state == ST_EXEC || state == ST_WB) ? alu_q : '0;
    assign write_reg = (state == ST_WB);
    assign branch_en = (state == ST_EXEC) && (cls_q == CLS_BRANCH);
    assign jump_en   = (state == ST_EXEC) && (cls_q == CLS_JUMP);
    assign halted    = (state == ST_HALT);
    assign error     = (state == ST_ERR);

endmodule

// File: tb/tb_multicycle_control.sv
// Self-checking bench for multicycle_control: drivers push the expected per-cycle
// output vector, a negedge monitor pops and compares.
module tb_multicycle_control;

    localparam int TMO = 15;

    logic       clk;
    logic       reset;
    logic       start;
    logic [3:0] opcode;
    logic       imm_flag;
    logic       mem_ready;
    logic       mem_req, mem_we, ir_load, pc_inc, write_reg, branch_en, jump_en, halted, error;
    logic [3:0] alu_inst;
    logic [1:0] retire_cnt;

    multicycle_control #(.OP_W(4), .ALU_W(4), .CNT_W(2), .TMO(TMO)) dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .opcode     (opcode),
        .imm_flag   (imm_flag),
        .mem_ready  (mem_ready),
        .mem_req    (mem_req),
        .mem_we     (mem_we),
        .ir_load    (ir_load),
        .pc_inc     (pc_inc),
        .alu_inst   (alu_inst),
        .write_reg  (write_reg),
        .branch_en  (branch_en),
        .jump_en    (jump_en),
        .halted     (halted),
        .error      (error),
        .retire_cnt (retire_cnt)
    );

    // Strobe vector order: mem_req mem_we ir_load pc_inc write_reg branch_en jump_en halted error
    localparam logic [8:0] S_NONE = 9'b000000000;
    localparam logic [8:0] S_WR   = 9'b000010000;
    localparam logic [8:0] S_BR   = 9'b000001000;
    localparam logic [8:0] S_JMP  = 9'b000000100;
    localparam logic [8:0] S_HALT = 9'b000000010;
    localparam logic [8:0] S_ERR  = 9'b000000001;

    logic [14:0] obs;
    assign obs = {mem_req, mem_we, ir_load, pc_inc, write_reg, branch_en, jump_en,
                  halted, error, alu_inst, retire_cnt};

    logic [14:0] exp_q[$];
    logic [1:0]  exp_ret;
    int          n_checks;
    int          n_pass;
    string       cur;

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- scoreboard monitor ----------------
    always @(negedge clk) begin
        logic [14:0] e;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            n_checks++;
            if (obs !== e)
                $display("FAIL %s: got %b expected %b (strobes|alu|retire)", cur, obs, e);
            else
                n_pass++;
        end
    end

    // ---------------- reference model ----------------
    // cls: 0 nop, 1 alu, 2 branch, 3 jump, 4 load, 5 store, 6 move, 7 halt
    function automatic void model_of(input logic [3:0] op, input logic imm,
                                     output int cls, output logic [3:0] alu);
        cls = 0;
        alu = 4'h0;
        case (op)
            4'b0111: begin cls = 1; alu = 4'b0000; end
            4'b1000: begin cls = 1; alu = 4'b0001; end
            4'b1001: begin cls = 1; alu = imm ? 4'b0011 : 4'b0010; end
            4'b1101: begin cls = 1; alu = imm ? 4'b0100 : 4'b0101; end
            4'b1010: begin cls = 2; alu = 4'b0110; end
            4'b1011: begin cls = 2; alu = 4'b0111; end
            4'b1100: begin cls = 2; alu = 4'b1000; end
            4'b0010: cls = 3;
            4'b0000, 4'b0001: cls = 4;
            4'b0011: cls = 5;
            4'b0100, 4'b0101, 4'b0110: cls = 6;
            4'b1110: cls = 7;
            default: cls = 0;
        endcase
    endfunction

    // ---------------- driver tasks ----------------
    task automatic cycle_exp(input logic [8:0] s, input logic [3:0] a);
        exp_q.push_back({s, a, exp_ret});
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset_start();
        reset = 1'b1; start = 1'b1; mem_ready = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0; mem_ready = 1'b0; exp_ret = 2'd0;
        cur = "idle_start";
        cycle_exp(S_NONE, 4'h0);
        start = 1'b0;
    endtask

    // Runs one instruction from FETCH; mdly < 0 means memory never answers in MEM.
    task automatic exec_instr(input string nm, input logic [3:0] op, input logic imm,
                              input int fdly, input int mdly);
        int         cls;
        int         n_mem;
        logic [3:0] ea;
        logic       st;
        model_of(op, imm, cls, ea);
        cur = nm;
        for (int i = 0; i <= fdly; i++) begin
            mem_ready = (i == fdly);
            cycle_exp({2'b10, mem_ready, mem_ready, 5'b0}, 4'h0);
        end
        mem_ready = 1'b0; opcode = op; imm_flag = imm;
        cycle_exp(S_NONE, 4'h0);
        opcode   = 4'($urandom_range(0, 15));
        imm_flag = 1'($urandom_range(0, 1));
        case (cls)
            1: begin cycle_exp(S_NONE, ea); cycle_exp(S_WR, ea); exp_ret = exp_ret + 2'd1; end
            2: begin cycle_exp(S_BR, ea); exp_ret = exp_ret + 2'd1; end
            3: begin cycle_exp(S_JMP, 4'h0); exp_ret = exp_ret + 2'd1; end
            4, 5: begin
                st    = (cls == 5);
                n_mem = (mdly < 0) ? TMO : mdly + 1;
                for (int i = 0; i < n_mem; i++) begin
                    mem_ready = (mdly >= 0) && (i == mdly);
                    cycle_exp({1'b1, st, 7'b0}, 4'h0);
                end
                mem_ready = 1'b0;
                if (mdly < 0) begin
                    cycle_exp(S_ERR, 4'h0);
                    cycle_exp(S_ERR, 4'h0);
                end else if (cls == 4) begin
                    cycle_exp(S_WR, 4'h0);
                    exp_ret = exp_ret + 2'd1;
                end else begin
                    exp_ret = exp_ret + 2'd1;
                end
            end
            6: begin cycle_exp(S_WR, 4'h0); exp_ret = exp_ret + 2'd1; end
            7: begin exp_ret = exp_ret + 2'd1; cycle_exp(S_HALT, 4'h0); end
            default: exp_ret = exp_ret + 2'd1;
        endcase
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        reset = 1'b1; start = 1'b1; mem_ready = 1'b1; opcode = 4'h7; imm_flag = 1'b0;
        @(posedge clk);
        #1;
        start = 1'b0; mem_ready = 1'b0;
        @(negedge clk);
        n_checks++;
        if (obs !== 15'd0) $display("FAIL reset_state: got %b expected all zero", obs);
        else n_pass++;
        @(posedge clk);
        #1;
        reset = 1'b0; exp_ret = 2'd0;
        cur = "idle_hold"; mem_ready = 1'b1;
        cycle_exp(S_NONE, 4'h0);
        cycle_exp(S_NONE, 4'h0);
        mem_ready = 1'b0; start = 1'b1;
        cycle_exp(S_NONE, 4'h0);
        start = 1'b0;
        exec_instr("add_first", 4'b0111, 1'b0, 0, 0);
        n_checks++;
        if (retire_cnt !== 2'd1) $display("FAIL add_retire: got %0d expected 1", retire_cnt);
        else n_pass++;
    endtask

    task automatic test_alu();
        do_reset_start();
        exec_instr("sft_imm1", 4'b1001, 1'b1, 0, 0);
        exec_instr("inc_imm0", 4'b1101, 1'b0, 0, 0);
        n_checks++;
        if (retire_cnt !== 2'd2) $display("FAIL sft_inc_retire: got %0d expected 2", retire_cnt);
        else n_pass++;
        exec_instr("sft_imm0", 4'b1001, 1'b0, 1, 0);
        exec_instr("inc_imm1", 4'b1101, 1'b1, 0, 0);
        exec_instr("sub", 4'b1000, 1'b1, 2, 0);
    endtask

    task automatic test_branch_jump();
        exec_instr("bne", 4'b1010, 1'b0, 0, 0);
        exec_instr("beq", 4'b1011, 1'b1, 1, 0);
        exec_instr("blt", 4'b1100, 1'b0, 0, 0);
        exec_instr("jmp", 4'b0010, 1'b0, 0, 0);
    endtask

    task automatic test_memory();
        exec_instr("lb", 4'b0000, 1'b0, 2, 0);
        exec_instr("lhb_slow", 4'b0001, 1'b0, 0, 2);
        exec_instr("str_delay3", 4'b0011, 1'b0, 0, 3);
        exec_instr("lb_mem_edge", 4'b0000, 1'b0, 0, TMO - 1);
        exec_instr("add_fetch_edge", 4'b0111, 1'b0, TMO - 1, 0);
    endtask

    task automatic test_move_nop();
        exec_instr("mvb", 4'b0101, 1'b0, 0, 0);
        exec_instr("mvf", 4'b0110, 1'b1, 0, 0);
        exec_instr("lim", 4'b0100, 1'b0, 1, 0);
        exec_instr("tba", 4'b1111, 1'b0, 0, 0);
    endtask

    task automatic test_back_to_back();
        logic [3:0] op;
        for (int k = 0; k < 24; k++) begin
            op = 4'($urandom_range(0, 15));
            if (op == 4'b1110) op = 4'b1111;
            exec_instr("random", op, 1'($urandom_range(0, 1)),
                       $urandom_range(0, 3), $urandom_range(0, 3));
        end
    endtask

    task automatic test_nop_wrap();
        logic [1:0] tab [5];
        tab = '{2'd1, 2'd2, 2'd3, 2'd0, 2'd1};
        do_reset_start();
        for (int k = 0; k < 5; k++) begin
            exec_instr("nop_wrap", 4'b1111, 1'b0, 0, 0);
            n_checks++;
            if (retire_cnt !== tab[k])
                $display("FAIL nop_wrap_%0d: got %0d expected %0d", k, retire_cnt, tab[k]);
            else n_pass++;
        end
    endtask

    task automatic test_reset_mid_mem();
        do_reset_start();
        cur = "rst_mid_mem";
        mem_ready = 1'b1;
        cycle_exp({2'b10, 2'b11, 5'b0}, 4'h0);
        mem_ready = 1'b0; opcode = 4'b0000;
        cycle_exp(S_NONE, 4'h0);
        cycle_exp({2'b10, 7'b0}, 4'h0);
        reset = 1'b1; mem_ready = 1'b1;
        cycle_exp({2'b10, 7'b0}, 4'h0);
        reset = 1'b0; exp_ret = 2'd0;
        cycle_exp(S_NONE, 4'h0);
        mem_ready = 1'b0;
        n_checks++;
        if (mem_req !== 1'b0) $display("FAIL rst_mid_mem_req: got %b expected 0", mem_req);
        else n_pass++;
    endtask

    task automatic test_timeout();
        do_reset_start();
        cur = "fetch_timeout";
        mem_ready = 1'b0;
        for (int i = 0; i < TMO; i++) cycle_exp({2'b10, 7'b0}, 4'h0);
        for (int i = 0; i < 4; i++) begin
            start     = 1'($urandom_range(0, 1));
            mem_ready = 1'($urandom_range(0, 1));
            cycle_exp(S_ERR, 4'h0);
        end
        start = 1'b0; mem_ready = 1'b0;
        n_checks++;
        if (error !== 1'b1) $display("FAIL error_sticky: got %b expected 1", error);
        else n_pass++;
        do_reset_start();
        exec_instr("str_timeout", 4'b0011, 1'b0, 0, -1);
    endtask

    task automatic test_halt();
        do_reset_start();
        exec_instr("mvb_pre_halt", 4'b0101, 1'b0, 0, 0);
        exec_instr("halt", 4'b1110, 1'b0, 0, 0);
        cur = "halt_sticky";
        for (int i = 0; i < 4; i++) begin
            start     = ~start;
            mem_ready = 1'b1;
            cycle_exp(S_HALT, 4'h0);
        end
        start = 1'b0; mem_ready = 1'b0;
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0; exp_ret = 2'd0;
        n_checks++;
        if (halted !== 1'b0) $display("FAIL halt_cleared: got %b expected 0", halted);
        else n_pass++;
        cur = "post_halt_idle";
        cycle_exp(S_NONE, 4'h0);
    endtask

    initial begin
        n_checks = 0; n_pass = 0; exp_ret = 2'd0; cur = "init";
        reset = 1'b1; start = 1'b0; opcode = 4'h0; imm_flag = 1'b0; mem_ready = 1'b0;
        test_reset();
        test_alu();
        test_branch_jump();
        test_memory();
        test_move_nop();
        test_back_to_back();
        test_nop_wrap();
        test_reset_mid_mem();
        test_timeout();
        test_halt();
        @(posedge clk);
        #1;
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/multicycle_control.md
MULTICYCLE_CONTROL -- requirements
Module: multicycle_control

Interface
REQ-001 Parameter OP_W, default 4, opcode width.
REQ-002 Parameter ALU_W, default 4, alu_inst width.
REQ-003 Parameter CNT_W, default 16, retired-instruction counter width.
REQ-004 Parameter TMO, default 15, max wait cycles for mem_ready before error; TMO>=1.
REQ-005 One clock; reset is synchronous and active-high.
REQ-006 clk  in  1  sole clock, rising edge.
REQ-007 reset  in  1  synchronous, active-high.
REQ-008 start  in  1  leave IDLE and begin fetching.
REQ-009 opcode  in  OP_W  opcode field of instruction register.
REQ-010 imm_flag  in  1  selects shift direction / inc vs dec.
REQ-011 mem_ready  in  1  memory completes current request this cycle.
REQ-012 mem_req  out  1  memory request (fetch or data).
REQ-013 mem_we  out  1  write strobe, valid with mem_req.
REQ-014 ir_load  out  1  load instruction register.
REQ-015 pc_inc  out  1  advance PC.
REQ-016 alu_inst  out  ALU_W  ALU operation code.
REQ-017 write_reg  out  1  register-file write enable.
REQ-018 branch_en  out  1  conditional branch evaluate/take.
REQ-019 jump_en  out  1  unconditional PC load.
REQ-020 halted  out  1  HALT executed; sticky.
REQ-021 error  out  1  memory timeout; sticky.
REQ-022 retire_cnt  out  CNT_W  instructions retired.

Function
REQ-023 States: IDLE, FETCH, DECODE, EXEC, MEM, WB, HALT, ERR; all outputs are Moore functions of state and registered opcode class.
REQ-024 IDLE->FETCH when start=1; otherwise hold.
REQ-025 FETCH: mem_req=1, mem_we=0; on mem_ready: ir_load=1, pc_inc=1 same cycle, ->DECODE.
REQ-026 DECODE: opcode/imm_flag sampled and class registered; next state per class.
REQ-027 ALU class (ADD 0111, SUB 1000, SFT 1001, INC 1101): DECODE->EXEC->WB; alu_inst in EXEC and WB: ADD 0000, SUB 0001, SFT imm 0011 else 0010, INC imm 0100 else 0101.
REQ-028 Branch class (BNE 1010, BEQ 1011, BLT 1100): DECODE->EXEC; EXEC drives alu_inst 0110/0111/1000, branch_en=1; ->FETCH.
REQ-029 JMP 0010: DECODE->EXEC, jump_en=1, ->FETCH.
REQ-030 Memory class LB 0000, LHB 0001: DECODE->MEM (mem_req=1, mem_we=0) ->WB on mem_ready; STR 0011: MEM with mem_we=1, ->FETCH on mem_ready.
REQ-031 Move class MVB 0101, MVF 0110, LIM 0100: DECODE->WB.
REQ-032 WB: write_reg=1 exactly one cycle, ->FETCH.
REQ-033 HALT 1110: DECODE->HALT; halted=1; remain until reset; start ignored.
REQ-034 TBA 1111: NOP, DECODE->FETCH.
REQ-035 Outside listed states alu_inst=0; all strobes 0 unless stated.
REQ-036 retire_cnt increments by 1 on every transition into FETCH from DECODE/EXEC/MEM/WB and on entering HALT; wraps 2^CNT_W-1 -> 0.
REQ-037 Wait counter clears on entry to FETCH/MEM; if mem_ready not seen within TMO cycles -> ERR; mem_ready in cycle TMO succeeds.
REQ-038 ERR: error=1, all strobes 0, hold until reset.
REQ-039 Latencies with mem_ready immediate: ALU 4 cycles, branch/JMP 3, move 3, LB 4, STR 3, TBA 2.

Reset
REQ-040 reset=1 at clk edge: state IDLE, retire_cnt 0, wait counter 0, halted 0, error 0, all strobes 0, alu_inst 0; overrides any in-flight request.
REQ-041 reset dominates start, mem_ready and all other inputs in the same cycle.

Structure
REQ-042 Opcode and ALUOP encodings, state enum, and class enum SHALL live in shared package ctrl_pkg.
REQ-043 Combinational opcode-to-class/alu_inst mapping SHALL be sub-module ctrl_decode; FSM, counters in top.

Verification
REQ-044 reset, start, ADD (0111) with mem_ready=1 -> ir_load cycle 1, alu_inst 0000 in EXEC, write_reg one cycle in WB, retire_cnt=1.
REQ-045 SFT imm_flag=1 then INC imm_flag=0 -> alu_inst 0011 then 0101; retire_cnt=2.
REQ-046 STR with mem_ready delayed 3 cycles -> mem_req+mem_we held 4 cycles, no write_reg, ->FETCH.
REQ-047 TMO=15, mem_ready never in FETCH -> error=1 after cycle 15, strobes 0 until reset.
REQ-048 HALT (1110) then start pulses -> halted=1 sticky, no mem_req; reset -> IDLE, halted=0.
REQ-049 CNT_W=2, five NOPs (1111) -> retire_cnt 1,2,3,0,1; reset asserted mid-MEM -> IDLE next cycle.
